// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 16-bit 5-stage core's branch logic:
//   - opcode constants for the branch and halt instructions
//   - condition-code (ccc) encodings
//   - the branch/flush controller state enum
//   - bit positions inside the {Z,V,N} flag vector
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Instruction opcodes (instr[15:12])
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Condition codes (instr[11:9])
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;

    // Flag vector layout: {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FLUSH  = 2'b01,
        HALTED = 2'b10
    } flush_state_t;

endpackage : pipe_pkg

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Purely combinational branch condition evaluation. Kept as its own block so
// a future branch predictor can evaluate conditions with the same logic.
// Ports:
//   ccc   in  3  condition code field of the branch instruction
//   flags in  3  {Z,V,N} flag register
//   cond  out 1  condition satisfied
// ---------------------------------------------------------------------------
module branch_cond
    import pipe_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond
);

    logic flag_z;
    logic flag_v;
    logic flag_n;

    assign flag_z = flags[FLAG_Z];
    assign flag_v = flags[FLAG_V];
    assign flag_n = flags[FLAG_N];

    always_comb begin
        cond = 1'b0;
        case (ccc)
            CC_NE:   cond = !flag_z;
            CC_EQ:   cond = flag_z;
            CC_GT:   cond = !flag_z && !flag_n;
            CC_LT:   cond = flag_n;
            CC_GE:   cond = flag_z || (!flag_z && !flag_n);
            CC_LE:   cond = flag_n || flag_z;
            CC_OV:   cond = flag_v;
            CC_UN:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule : branch_cond

// File: rtl/branch_flush_ctrl.sv
// ---------------------------------------------------------------------------
// branch_flush_ctrl
// Resolves B/BR in EX, redirects the PC and drives the flush that squashes
// wrong-path instructions in IF/ID and ID/EX (and clears the hazard unit's
// HLT shift chain). Also freezes the PC once a halt is accepted.
//
// Optional feature macro: FLUSH_STATS_EN
//   defined   -> adds flush_count[15:0], saturating count of taken branches
//   undefined -> no counter, no port
//
// Parameter:
//   FLUSH_CYCLES  cycles flush stays high after a taken branch (1..3)
// Ports:
//   clk          in   1   core clock
//   rst          in   1   asynchronous reset, active-low
//   ex_valid     in   1   ID/EX holds a real instruction
//   ex_instr     in   16  ID/EX instruction
//   ex_flags     in   3   {Z,V,N} flags as seen by EX
//   ex_pc_plus2  in   16  PC+2 of the EX instruction
//   ex_rs_data   in   16  forwarded rs value (BR target)
//   stall        in   1   hazard-unit stall (does not gate branch resolution)
//   hlt          in   1   hazard-unit sticky halt
//   pc_redirect  out  1   one-cycle pulse: load pc_target into the PC
//   pc_target    out  16  redirect address
//   flush        out  1   squash IF/ID and ID/EX
//   pc_freeze    out  1   PC write disable while halted
//   flush_count  out  16  taken-branch count (FLUSH_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_flush_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_instr,
    input  logic [2:0]  ex_flags,
    input  logic [15:0] ex_pc_plus2,
    input  logic [15:0] ex_rs_data,
    input  logic        stall,
    input  logic        hlt,
    output logic        pc_redirect,
    output logic [15:0] pc_target,
    output logic        flush,
    output logic        pc_freeze
`ifdef FLUSH_STATS_EN
    ,
    output logic [15:0] flush_count
`endif
);

    // The counter holds the number of flush cycles still to come after the
    // current one, so it is loaded with FLUSH_CYCLES-1.
    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    // The EX instruction always advances, so stall has no effect on branch
    // resolution; it is accepted only to keep the hazard-unit interface whole.
    logic unused_stall;
    assign unused_stall = stall;

    // ---- stage p0: decode and resolve in EX (combinational) ----
    logic [3:0]         opcode_p0;
    logic               is_b_p0;
    logic               is_br_p0;
    logic               cond_p0;
    logic signed [15:0] b_offset_p0;
    logic [15:0]        target_p0;
    logic               taken_p0;

    flush_state_t state_q;
    flush_state_t state_d;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         vld_p1;
    logic         vld_d;
    logic [15:0]  target_p1;
    logic [15:0]  target_d;

    assign opcode_p0 = ex_instr[15:12];
    assign is_b_p0   = (opcode_p0 == OP_B);
    assign is_br_p0  = (opcode_p0 == OP_BR);

    branch_cond u_branch_cond (
        .ccc   (ex_instr[11:9]),
        .flags (ex_flags),
        .cond  (cond_p0)
    );

    // Word offset: sign-extend the 9-bit field and scale to bytes.
    assign b_offset_p0 = {{6{ex_instr[8]}}, ex_instr[8:0], 1'b0};
    assign target_p0   = is_br_p0 ? ex_rs_data
                                  : (ex_pc_plus2 + $unsigned(b_offset_p0));

    // Branches arriving during FLUSH are wrong-path; in HALTED nothing runs.
    assign taken_p0 = ex_valid && (is_b_p0 || is_br_p0) && cond_p0
                      && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = 1'b0;
        target_d = target_p1;
        case (state_q)
            IDLE: begin
                // A taken branch beats a concurrent halt: its flush clears
                // the pending HLT from the hazard chain.
                if (taken_p0) begin
                    state_d  = FLUSH;
                    cnt_d    = CNT_INIT;
                    vld_d    = 1'b1;
                    target_d = target_p0;
                end else if (hlt) begin
                    state_d = HALTED;
                end
            end
            FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- stage p1: registered redirect, target and control state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            vld_p1    <= 1'b0;
            target_p1 <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vld_p1    <= vld_d;
            target_p1 <= target_d;
        end
    end

    assign pc_redirect = vld_p1;
    assign pc_target   = target_p1;
    assign flush       = (state_q == FLUSH);
    assign pc_freeze   = (state_q == HALTED);

`ifdef FLUSH_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : (val + 16'd1);
    endfunction

    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'h0000;
        end else if (taken_p0) begin
            count_q <= sat_inc16(count_q);
        end
    end

    assign flush_count = count_q;
`endif

endmodule : branch_flush_ctrl

// File: tb/tb_branch_flush_ctrl.sv
module tb_branch_flush_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_instr = 16'h0000;
    logic [2:0]  ex_flags = 3'b000;
    logic [15:0] ex_pc_plus2 = 16'h0000;
    logic [15:0] ex_rs_data = 16'h0000;
    logic        stall = 1'b0;
    logic        hlt = 1'b0;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic        flush;
    logic        pc_freeze;
`ifdef FLUSH_STATS_EN
    logic [15:0] flush_count;
`endif

    branch_flush_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_instr    (ex_instr),
        .ex_flags    (ex_flags),
        .ex_pc_plus2 (ex_pc_plus2),
        .ex_rs_data  (ex_rs_data),
        .stall       (stall),
        .hlt         (hlt),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .flush       (flush),
        .pc_freeze   (pc_freeze)
`ifdef FLUSH_STATS_EN
        ,
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redirect;
        logic [15:0] target;
        logic        flush;
        logic        freeze;
        logic [15:0] count;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model: remaining flush cycles (counting the one currently on
    // the outputs), halt flag, last redirect target, taken-branch count.
    int          m_fl;
    bit          m_halted;
    logic [15:0] m_target;
    int          m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit cond_of(input logic [2:0] ccc, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_fl = 0; m_halted = 0; m_target = 16'h0000; m_count = 0;
    endtask

    // Drive one cycle of EX inputs and push the outputs expected after the edge.
    task automatic step(input bit v, input logic [15:0] ins, input logic [2:0] f,
                        input logic [15:0] pc2, input logic [15:0] rs,
                        input bit st, input bit h);
        exp_t e;
        bit   is_br, taken;
        int   off;
        @(negedge clk);
        ex_valid = v; ex_instr = ins; ex_flags = f; ex_pc_plus2 = pc2;
        ex_rs_data = rs; stall = st; hlt = h;
        is_br = (ins[15:12] == 4'hC) || (ins[15:12] == 4'hD);
        taken = v && is_br && cond_of(ins[11:9], f) && !m_halted && (m_fl == 0);
        if (taken) begin
            off = (ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0])) * 2;
            m_target = (ins[15:12] == 4'hD) ? rs : 16'((int'(pc2) + off) & 16'hFFFF);
            m_fl = FC;
            if (m_count < 16'hFFFF) m_count++;
        end else if (m_fl > 0) begin
            m_fl--;
        end else if (h) begin
            m_halted = 1;
        end
        e.redirect = taken;
        e.target   = m_target;
        e.flush    = (m_fl > 0);
        e.freeze   = m_halted;
        e.count    = 16'(m_count);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0000, 3'b000, 16'h0000, 16'h0000, 0, 0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_redirect", 32'(pc_redirect), 0);
        check("rst_flush",    32'(flush), 0);
        check("rst_freeze",   32'(pc_freeze), 0);
        check("rst_target",   32'(pc_target), 0);
        sb.delete();
        ex_valid = 0; hlt = 0; stall = 0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Monitor: compare every cycle's registered outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_redirect", 32'(pc_redirect), 32'(e.redirect));
                check("pc_target",   32'(pc_target),   32'(e.target));
                check("flush",       32'(flush),       32'(e.flush));
                check("pc_freeze",   32'(pc_freeze),   32'(e.freeze));
`ifdef FLUSH_STATS_EN
                check("flush_count", 32'(flush_count), 32'(e.count));
`endif
            end
        end
    end

    initial begin
        logic [15:0] ins, pc2, rs;
        logic [3:0]  op;
        int          r, halt_age;
        model_reset();
        #12;
        check("init_redirect", 32'(pc_redirect), 0);
        check("init_flush",    32'(flush), 0);
        check("init_target",   32'(pc_target), 0);
        @(negedge clk);
        rst = 1'b1;

        // B UN, offset 4 -> 0x0018
        step(1, {4'hC, 3'b111, 9'h004}, 3'b000, 16'h0010, 16'h0000, 0, 0);
        idle(4);
        // B EQ with Z=0; then Z=1 but bubble
        step(1, {4'hC, 3'b001, 9'h010}, 3'b000, 16'h0100, 16'h0000, 0, 0);
        step(0, {4'hC, 3'b001, 9'h010}, 3'b100, 16'h0100, 16'h0000, 0, 0);
        idle(2);
        // BR with stall, then wrapping B
        step(1, {4'hD, 3'b111, 9'h000}, 3'b000, 16'h2000, 16'hFFFE, 1, 0);
        idle(3);
        step(1, {4'hC, 3'b111, 9'h002}, 3'b000, 16'hFFFE, 16'h0000, 0, 0);
        idle(3);
        // Negative offset
        step(1, {4'hC, 3'b110, 9'h1FE}, 3'b010, 16'h0040, 16'h0000, 0, 0);
        idle(3);
        // Back-to-back taken branches: only the first redirects
        step(1, {4'hC, 3'b111, 9'h008}, 3'b000, 16'h0200, 16'h0000, 0, 0);
        step(1, {4'hC, 3'b111, 9'h020}, 3'b000, 16'h0300, 16'h0000, 0, 0);
        step(1, {4'hD, 3'b111, 9'h000}, 3'b000, 16'h0300, 16'hABCD, 0, 0);
        idle(3);
        // hlt with a taken branch, hlt held during flush, then hlt alone
        step(1, {4'hC, 3'b111, 9'h003}, 3'b000, 16'h0500, 16'h0000, 0, 1);
        step(0, 16'h0000, 3'b000, 16'h0000, 16'h0000, 0, 1);
        step(0, 16'h0000, 3'b000, 16'h0000, 16'h0000, 0, 0);
        idle(1);
        step(0, 16'hF000, 3'b000, 16'h0000, 16'h0000, 0, 1);
        step(1, {4'hC, 3'b111, 9'h003}, 3'b000, 16'h0600, 16'h0000, 0, 0);
        idle(3);
        do_reset();
        idle(2);
        // Reset in the middle of a flush
        step(1, {4'hD, 3'b111, 9'h000}, 3'b000, 16'h0000, 16'h1234, 0, 0);
        do_reset();
        idle(3);

        // Randomized traffic
        halt_age = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 4'hC : (r < 8) ? 4'hD : 4'($urandom);
            ins = {op, 12'($urandom)};
            pc2 = 16'($urandom);
            rs  = 16'($urandom);
            step($urandom_range(0, 4) != 0, ins, 3'($urandom), pc2, rs,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
            halt_age = m_halted ? halt_age + 1 : 0;
            if (halt_age > 6 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_age = 0;
            end
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_flush_ctrl
